// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the C2 memory bus.
// Each grant moves one line, split into BUS_SIZE-bit beats sent LSB beat first.
// A write sends its beats in the command phase. A read collects its beats after RESPONSE.
// A read or write that gets no RESPONSE within TIMEOUT cycles ends with an err pulse.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int BUS_SIZE  = 16,
    parameter int LINE_BITS = 128,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [2*ADDR_W-1:0]    req_addr,
    input  logic [2*LINE_BITS-1:0] req_wdata,
    output logic [1:0]             done,
    output logic [1:0]             err,
    output logic [LINE_BITS-1:0]   rdata,
    output logic                   busy,
    output logic                   grant_id,
    output logic [1:0]             mem_cmd_out,
    input  logic [1:0]             mem_cmd_in,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [BUS_SIZE-1:0]    mem_data_out,
    output logic                   mem_data_oe,
    input  logic [BUS_SIZE-1:0]    mem_data_in
);

    localparam int BEATS  = LINE_BITS / BUS_SIZE;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CMD_NOP      = 2'd0;
    localparam logic [1:0] CMD_RESPONSE = 2'd1;
    localparam logic [1:0] CMD_READ     = 2'd2;
    localparam logic [1:0] CMD_WRITE    = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]           state_reg, state_next;
    logic [BEAT_W-1:0]    beat_reg;
    logic [TMO_W-1:0]     tmo_reg;
    logic                 write_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [LINE_BITS-1:0] wdata_reg;
    logic [LINE_BITS-1:0] rbuf_reg;
    logic [LINE_BITS-1:0] rdata_reg;
    logic                 grant_reg;
    logic                 last_grant_reg;
    logic                 pick;
    logic                 resp_seen;
    logic                 last_beat;
    logic [BUS_SIZE-1:0]  wbeat [BEATS];

    // On a tie, grant the requester that was not granted last time. Otherwise grant the only one asking.
    assign pick      = (&req_valid) ? ~last_grant_reg : req_valid[1];
    assign resp_seen = (mem_cmd_in == CMD_RESPONSE);
    assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));

    // Split the latched write line into beats. Beat k is bits [k*BUS_SIZE +: BUS_SIZE].
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_wbeat
            assign wbeat[gi] = wdata_reg[gi*BUS_SIZE +: BUS_SIZE];
        end
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign done[gi] = (state_reg == S_DONE) && (int'(grant_reg) == gi);
            assign err[gi]  = (state_reg == S_ERR)  && (int'(grant_reg) == gi);
        end
    endgenerate

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (|req_valid) state_next = S_CMD;
            S_CMD:  if (!write_reg || last_beat) state_next = S_WAIT;
            S_WAIT: begin
                if (resp_seen)
                    state_next = write_reg ? S_DONE : S_RECV;
                else if (tmo_reg == TMO_W'(TIMEOUT - 1))
                    state_next = S_ERR;
            end
            S_RECV: if (last_beat) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            S_ERR:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, grant bookkeeping, beat/timeout counters and read line assembly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            beat_reg       <= '0;
            tmo_reg        <= '0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rbuf_reg       <= '0;
            rdata_reg      <= '0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        write_reg      <= req_write[pick];
                        addr_reg       <= pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        wdata_reg      <= pick ? req_wdata[2*LINE_BITS-1:LINE_BITS]
                                               : req_wdata[LINE_BITS-1:0];
                        beat_reg       <= '0;
                    end
                end
                S_CMD: begin
                    // Write beats advance here. The counter wraps back to 0 after the last beat.
                    if (write_reg) beat_reg <= beat_reg + 1'b1;
                    tmo_reg <= '0;
                end
                S_WAIT: begin
                    if (resp_seen) begin
                        // A read's first data beat arrives together with RESPONSE.
                        rbuf_reg[BUS_SIZE-1:0] <= mem_data_in;
                        beat_reg               <= BEAT_W'(1);
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                S_RECV: begin
                    rbuf_reg[int'(beat_reg)*BUS_SIZE +: BUS_SIZE] <= mem_data_in;
                    beat_reg <= beat_reg + 1'b1;
                    // Publish the whole line at once so rdata never shows a partial read.
                    if (last_beat)
                        rdata_reg <= {mem_data_in, rbuf_reg[LINE_BITS-BUS_SIZE-1:0]};
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_reg != S_IDLE);
    assign grant_id     = grant_reg;
    assign rdata        = rdata_reg;
    assign mem_cmd_out  = (state_reg == S_CMD) ? (write_reg ? CMD_WRITE : CMD_READ) : CMD_NOP;
    assign mem_addr     = (state_reg == S_CMD) ? addr_reg : '0;
    assign mem_data_oe  = (state_reg == S_CMD) && write_reg;
    assign mem_data_out = mem_data_oe ? wbeat[beat_reg] : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter.
// The bench plays the memory side itself. Each request pushes its expected outcome into a queue.
// That entry is popped and compared when done or err is seen.
module tb_mem_bus_arbiter;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_write;
    logic [29:0]   req_addr;
    logic [255:0]  req_wdata;
    logic [1:0]    done;
    logic [1:0]    err;
    logic [127:0]  rdata;
    logic          busy;
    logic          grant_id;
    logic [1:0]    mem_cmd_out;
    logic [1:0]    mem_cmd_in;
    logic [14:0]   mem_addr;
    logic [15:0]   mem_data_out;
    logic          mem_data_oe;
    logic [15:0]   mem_data_in;

    typedef struct packed {
        logic [1:0]   id_bits;
        logic         is_err;
        logic [127:0] rdata;
    } sb_t;

    sb_t          sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [127:0] exp_rdata;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .grant_id     (grant_id),
        .mem_cmd_out  (mem_cmd_out),
        .mem_cmd_in   (mem_cmd_in),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_oe  (mem_data_oe),
        .mem_data_in  (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input int id, input logic wr, input logic [14:0] addr,
                           input logic [127:0] wdata);
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id*15 +: 15]    = addr;
        req_wdata[id*128 +: 128] = wdata;
    endtask

    // Serve one granted transaction as memory.
    // lat is the WAIT_RESP cycle (1-based) that carries RESPONSE. A negative lat means memory never answers.
    task automatic serve(input int id, input logic wr, input logic [14:0] addr,
                         input logic [127:0] wdata, input int lat, input logic [127:0] rline,
                         input logic hold, output int cmd_cyc, output int done_cyc);
        sb_t  it, got_it;
        logic got;
        logic idb;
        int   n_wait;
        idb        = id[0];
        it.id_bits = idb ? 2'b10 : 2'b01;
        it.is_err  = (lat < 0);
        it.rdata   = (wr || it.is_err) ? exp_rdata : rline;
        if (!wr && !it.is_err) exp_rdata = rline;
        sb.push_back(it);
        cmd_cyc  = 0;
        done_cyc = 0;

        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            if (mem_cmd_out != NOP) got = 1'b1;
        end
        check("cmd_seen", 128'(got), 128'(1'b1));
        if (!got) begin
            void'(sb.pop_front());
            return;
        end
        cmd_cyc = cyc;
        check("grant_id", 128'(grant_id), 128'(idb));
        check("mem_addr", 128'(mem_addr), 128'(addr));
        check("cmd", 128'(mem_cmd_out), 128'(wr ? WR : RD));
        if (wr) begin
            for (int k = 0; k < 8; k++) begin
                if (k > 0) @(negedge clk);
                check("wr_cmd", 128'(mem_cmd_out), 128'(WR));
                check("wr_oe", 128'(mem_data_oe), 128'(1'b1));
                check("wr_beat", 128'(mem_data_out), 128'(wdata[k*16 +: 16]));
            end
        end

        n_wait = it.is_err ? 255 : lat;
        for (int j = 1; j <= n_wait; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check("wait_cmd", 128'(mem_cmd_out), 128'(NOP));
                check("wait_oe", 128'(mem_data_oe), 128'(1'b0));
            end
            if (j == n_wait) check("no_early_resp", 128'({done, err}), 128'(4'b0000));
            if (!it.is_err && j == lat) begin
                mem_cmd_in  = RESP;
                mem_data_in = rline[15:0];
            end else begin
                mem_cmd_in  = NOP;
                mem_data_in = 16'h0000;
            end
        end
        if (!wr && !it.is_err) begin
            for (int b = 1; b < 8; b++) begin
                @(negedge clk);
                mem_cmd_in  = NOP;
                mem_data_in = rline[b*16 +: 16];
            end
        end

        @(negedge clk);
        mem_cmd_in  = NOP;
        mem_data_in = 16'h0000;
        done_cyc    = cyc;
        got_it      = sb.pop_front();
        check("done", 128'(done), 128'(got_it.is_err ? 2'b00 : got_it.id_bits));
        check("err", 128'(err), 128'(got_it.is_err ? got_it.id_bits : 2'b00));
        check("rdata", rdata, got_it.rdata);
        $display("[TB] txn req=%0d %s addr=%h done=%b err=%b rdata=%h", id, wr ? "WR" : "RD",
                 addr, done, err, rdata);
        if (!hold) req_valid[id] = 1'b0;
    endtask

    initial begin
        int c1, d1, c2, d2;
        logic got;
        reset       = 1'b0;
        req_valid   = 2'b00;
        req_write   = 2'b00;
        req_addr    = '0;
        req_wdata   = '0;
        mem_cmd_in  = NOP;
        mem_data_in = 16'h0000;
        exp_rdata   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outs", 128'({done, err, busy, grant_id, mem_cmd_out, mem_addr, mem_data_out,
                                 mem_data_oe}), 128'(0));
        check("reset_rdata", rdata, 128'(0));
        reset = 1'b1;
        @(negedge clk);

        // Single read
        request(0, 1'b0, 15'h1234, 128'(0));
        serve(0, 1'b0, 15'h1234, 128'(0), 3, 128'h0008_0007_0006_0005_0004_0003_0002_0001,
              1'b0, c1, d1);
        @(negedge clk);
        check("busy_after_read", 128'(busy), 128'(1'b0));

        // Single write from requester 1
        request(1, 1'b1, 15'h7FFF, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        serve(1, 1'b1, 15'h7FFF, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 2, 128'(0),
              1'b0, c1, d1);

        // Round robin with both requesters continuously valid
        @(negedge clk);
        request(0, 1'b0, 15'h0111, 128'(0));
        request(1, 1'b1, 15'h0222, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        serve(0, 1'b0, 15'h0111, 128'(0), 1, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
              1'b1, c1, d1);
        serve(1, 1'b1, 15'h0222, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 4, 128'(0),
              1'b1, c1, d1);
        serve(0, 1'b0, 15'h0111, 128'(0), 2, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000,
              1'b1, c1, d1);
        serve(1, 1'b1, 15'h0222, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 1, 128'(0),
              1'b1, c1, d1);
        req_valid = 2'b00;

        // Timeout with no response, then a normal request
        @(negedge clk);
        request(0, 1'b0, 15'h0555, 128'(0));
        serve(0, 1'b0, 15'h0555, 128'(0), -1, 128'(0), 1'b0, c1, d1);
        request(1, 1'b0, 15'h0666, 128'(0));
        serve(1, 1'b0, 15'h0666, 128'(0), 2, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10,
              1'b0, c1, d1);

        // RESPONSE on the last allowed WAIT_RESP cycle completes normally
        request(0, 1'b0, 15'h0777, 128'(0));
        serve(0, 1'b0, 15'h0777, 128'(0), 255, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0,
              1'b0, c1, d1);

        // Reset during RECV beat 4
        request(0, 1'b0, 15'h0ABC, 128'(0));
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            if (mem_cmd_out == RD) got = 1'b1;
        end
        check("rst_cmd_seen", 128'(got), 128'(1'b1));
        @(negedge clk);
        mem_cmd_in  = RESP;
        mem_data_in = 16'hA000;
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            mem_cmd_in  = NOP;
            mem_data_in = 16'hA000 + 16'(b);
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_outs", 128'({done, err, busy, grant_id, mem_cmd_out, mem_addr,
                                  mem_data_out, mem_data_oe}), 128'(0));
        check("midrst_rdata", rdata, 128'(0));
        $display("[TB] txn reset mid-read busy=%b rdata=%h", busy, rdata);
        exp_rdata = '0;
        mem_data_in = 16'h0000;
        reset = 1'b1;
        request(0, 1'b0, 15'h0321, 128'(0));
        request(1, 1'b0, 15'h0654, 128'(0));
        serve(0, 1'b0, 15'h0321, 128'(0), 1, 128'h0A0B_0C0D_0E0F_1011_1213_1415_1617_1819,
              1'b0, c1, d1);
        serve(1, 1'b0, 15'h0654, 128'(0), 3, 128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F,
              1'b0, c1, d1);

        // Held valid: requester 0 re-granted right after DONE -> IDLE
        request(0, 1'b0, 15'h0042, 128'(0));
        serve(0, 1'b0, 15'h0042, 128'(0), 2, 128'h5A5A_0001_5A5A_0002_5A5A_0003_5A5A_0004,
              1'b1, c1, d1);
        serve(0, 1'b0, 15'h0042, 128'(0), 1, 128'hA5A5_0005_A5A5_0006_A5A5_0007_A5A5_0008,
              1'b0, c2, d2);
        check("regrant_gap", 128'(c2 - d1), 128'(2));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits between two line-granular requesters (I-side = requester 0, D-side = requester 1) and the single C2 memory bus.
- Arbitrates round-robin and sequences one 16-byte line transfer at a time as LINE_BITS/BUS_SIZE beats.
- Uses the C2 command encoding: NOP=0, RESPONSE=1, READ=2, WRITE=3.
- Returns read data or write completion to the granted requester, with a response timeout.

Parameters:
- ADDR_W, 15, line address width.
- BUS_SIZE, 16, data bits per beat.
- LINE_BITS, 128, line width; BEATS = LINE_BITS/BUS_SIZE = 8.
- TIMEOUT, 255, max cycles spent in WAIT_RESP before abort.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- req_valid  in  2  per-requester request; held until done/err.
- req_write  in  2  per-requester 1=write line, 0=read line.
- req_addr  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*LINE_BITS  requester i at [i*LINE_BITS +: LINE_BITS].
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  2  one-cycle timeout pulse to the granted requester.
- rdata  out  LINE_BITS  read line; valid in the done cycle.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  index of the current or last granted requester.
- mem_cmd_out  out  2  C2 command to memory.
- mem_cmd_in  in  2  C2 command from memory (RESPONSE).
- mem_addr  out  ADDR_W  line address.
- mem_data_out  out  BUS_SIZE  write beat.
- mem_data_oe  out  1  high while the controller drives write beats.
- mem_data_in  in  BUS_SIZE  read beat.

Behaviour:
- Reset values: state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie. Beat, timeout and latched registers are cleared.
- Reset mid-transfer aborts immediately. No done/err is issued, and mem_cmd_out=NOP in the cycle after reset.
- IDLE:
  - One valid request: grant it.
  - Both valid: grant !last_grant.
  - At the grant edge, latch write, addr and wdata; set grant_id and last_grant; go to CMD.
- CMD (read): drive mem_cmd_out=READ and mem_addr for exactly 1 cycle, then go to WAIT_RESP.
- CMD (write):
  - Hold mem_cmd_out=WRITE, mem_addr and mem_data_oe=1 for BEATS consecutive cycles.
  - Beat k = wdata[k*BUS_SIZE +: BUS_SIZE], k=0..7, LSB beat first.
  - Then go to WAIT_RESP with oe=0 and cmd=NOP.
- WAIT_RESP:
  - mem_cmd_out=NOP; the timeout counter increments each cycle.
  - On mem_cmd_in==RESPONSE:
    - Write: go to DONE.
    - Read: capture mem_data_in as beat 0 in that same cycle, then go to RECV.
  - If the counter reaches TIMEOUT with no RESPONSE, go to ERR.
  - RESPONSE sampled in the same cycle the counter hits TIMEOUT wins (no error).
- RECV: capture mem_data_in into beats 1..7 on the next 7 consecutive cycles, then go to DONE. mem_cmd_in is ignored.
- DONE: pulse done[grant_id]=1 for 1 cycle. rdata holds the assembled line (writes: rdata unchanged). Return to IDLE.
- ERR: pulse err[grant_id]=1 for 1 cycle, then go to IDLE.
- Requester obligations: drop req_valid in the cycle after done/err. The IDLE cycle following DONE/ERR re-samples req_valid, so a requester that keeps valid high is re-granted (it gets a second transaction).
- Latency:
  - Read: grant edge → CMD 1 → wait L → 8 beats → done. Total 1+1+L+7+1 cycles from the valid-sampled edge, where L = cycles to RESPONSE.
  - Write: 1 + 8 + L + 1.
- Changes to req_addr/req_wdata after the grant are ignored.
- Requests arriving while busy wait. No preemption.
- rdata holds its value until the next read completes.

Test Plan:
- Single read: req_valid=01, addr=0x1234, memory responds 3 cycles after READ with beats 0x0001..0x0008 → mem_cmd_out=READ for 1 cycle with mem_addr=0x1234; done=01 with rdata=0x0008_0007_..._0001; busy drops the next cycle.
- Single write: requester 1, addr=0x7FFF, wdata=128'h0F0E...0100 → 8 cycles of WRITE with oe=1 and beats 0x0100,0x0302,...,0x0F0E; RESPONSE after 2 cycles → done=10, rdata unchanged.
- Round robin: both requesters valid continuously for 4 transactions → grant order 0,1,0,1; each done pulses only its own bit.
- Timeout: TIMEOUT=255, memory never responds → err pulse exactly 255 cycles after entering WAIT_RESP; done stays 0; next request serviced normally. RESPONSE at cycle 255 → done, no err.
- Reset mid-read: reset=0 during RECV beat 4 → after the edge all outputs 0, state IDLE; the next tie grants requester 0.
- Held valid: requester 0 keeps valid after done, requester 1 idle → requester 0 is re-granted with no dead cycle beyond DONE→IDLE.
